// File: rtl/riscv_core_amo_unit.sv
// riscv_core_amo_unit
//   Read-modify-write sequencer for RISC-V A-extension AMO instructions.
//   It takes one AMO request from the core, reads the aligned 64-bit word,
//   applies the combine function, writes the result back and returns the
//   original memory value. Only one operation is in flight. The core is held
//   off through o_req_ready until the response handshake completes.
//
//   Optional feature macro: RISCV_AMO_WORD_EN
//     defined   : .W (32-bit) AMOs are supported on either half of the word.
//     undefined : any .W request is answered with o_rsp_err and no memory
//                 access, and no 32-bit combine or byte-enable logic exists.
//
// Ports
//   i_clk, i_rst           clock and synchronous active-high reset
//   i_req_*, o_req_ready   AMO request from the core (addr, rs2, op, .W flag)
//   o_rsp_*, i_rsp_ready   response to the core (original value, error flag)
//   o_mem_*, i_mem_*       single-port data-memory request/response channel
module riscv_core_amo_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH-1:0]   i_req_data,
   input  logic [3:0]              i_req_amo_op,
   input  logic                    i_req_word,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_data,
   output logic                    o_rsp_err,
   output logic                    o_mem_req_valid,
   input  logic                    i_mem_req_ready,
   output logic                    o_mem_we,
   output logic [ADDR_WIDTH-1:0]   o_mem_addr,
   output logic [DATA_WIDTH-1:0]   o_mem_wdata,
   output logic [DATA_WIDTH/8-1:0] o_mem_be,
   input  logic                    i_mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [BE_W-1:0] BE_ALL = '1;

   localparam logic [3:0] OP_SWAP = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MAX  = 4'd5;
   localparam logic [3:0] OP_MIN  = 4'd6;
   localparam logic [3:0] OP_MAXU = 4'd7;
   localparam logic [3:0] OP_MINU = 4'd8;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [3:0]              op_q;
   // Holds the value returned to the core, already formatted (sign-extended
   // half for .W) so the response stage is a plain copy.
   logic [DATA_WIDTH-1:0]   old_q;
   logic                    req_err;

   function automatic logic [DATA_WIDTH-1:0] amo_combine_d(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] mem,
      input logic [DATA_WIDTH-1:0] rs2
   );
      logic signed [DATA_WIDTH-1:0] mem_s;
      logic signed [DATA_WIDTH-1:0] rs2_s;
      mem_s = mem;
      rs2_s = rs2;
      case (op)
         OP_SWAP: return rs2;
         OP_ADD:  return mem + rs2;
         OP_AND:  return mem & rs2;
         OP_OR:   return mem | rs2;
         OP_XOR:  return mem ^ rs2;
         OP_MAX:  return (mem_s > rs2_s) ? mem : rs2;
         OP_MIN:  return (mem_s < rs2_s) ? mem : rs2;
         OP_MAXU: return (mem > rs2) ? mem : rs2;
         OP_MINU: return (mem < rs2) ? mem : rs2;
         default: return mem;
      endcase
   endfunction

`ifdef RISCV_AMO_WORD_EN
   localparam int HALF = DATA_WIDTH / 2;
   localparam logic [BE_W-1:0] BE_LO = {{(BE_W/2){1'b0}}, {(BE_W/2){1'b1}}};
   localparam logic [BE_W-1:0] BE_HI = ~BE_LO;

   logic            word_q;
   logic            hi_q;
   logic [HALF-1:0] rd_half;
   logic [HALF-1:0] wr_half;

   function automatic logic [HALF-1:0] amo_combine_w(
      input logic [3:0]      op,
      input logic [HALF-1:0] mem,
      input logic [HALF-1:0] rs2
   );
      logic signed [HALF-1:0] mem_s;
      logic signed [HALF-1:0] rs2_s;
      mem_s = mem;
      rs2_s = rs2;
      case (op)
         OP_SWAP: return rs2;
         OP_ADD:  return mem + rs2;
         OP_AND:  return mem & rs2;
         OP_OR:   return mem | rs2;
         OP_XOR:  return mem ^ rs2;
         OP_MAX:  return (mem_s > rs2_s) ? mem : rs2;
         OP_MIN:  return (mem_s < rs2_s) ? mem : rs2;
         OP_MAXU: return (mem > rs2) ? mem : rs2;
         OP_MINU: return (mem < rs2) ? mem : rs2;
         default: return mem;
      endcase
   endfunction

   // addr[2] picks the upper half of the 64-bit word
   assign rd_half = hi_q ? i_mem_rdata[DATA_WIDTH-1:HALF] : i_mem_rdata[HALF-1:0];
   assign wr_half = amo_combine_w(op_q, rd_half, data_q[HALF-1:0]);
`endif

   // Request screening: misalignment, illegal opcode, unsupported .W
   always_comb begin
      req_err = (i_req_amo_op > OP_MINU);
`ifdef RISCV_AMO_WORD_EN
      if (i_req_word) begin
         req_err = req_err | (i_req_addr[1:0] != 2'b00);
      end else begin
         req_err = req_err | (i_req_addr[2:0] != 3'b000);
      end
`else
      req_err = req_err | i_req_word | (i_req_addr[2:0] != 3'b000);
`endif
   end

   assign o_req_ready = (state == IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= IDLE;
         o_rsp_valid     <= 1'b0;
         o_rsp_data      <= '0;
         o_rsp_err       <= 1'b0;
         o_mem_req_valid <= 1'b0;
         o_mem_we        <= 1'b0;
         o_mem_addr      <= '0;
         o_mem_wdata     <= '0;
         o_mem_be        <= '0;
      end else begin
         case (state)
            // ---- accept: latch operands, screen, launch read or error ----
            IDLE: begin
               if (i_req_valid) begin
                  data_q <= i_req_data;
                  op_q   <= i_req_amo_op;
`ifdef RISCV_AMO_WORD_EN
                  word_q <= i_req_word;
                  hi_q   <= i_req_addr[2];
`endif
                  if (req_err) begin
                     state       <= RSP;
                     o_rsp_valid <= 1'b1;
                     o_rsp_data  <= '0;
                     o_rsp_err   <= 1'b1;
                  end else begin
                     state           <= RD_REQ;
                     o_mem_req_valid <= 1'b1;
                     o_mem_we        <= 1'b0;
                     o_mem_addr      <= {i_req_addr[ADDR_WIDTH-1:3], 3'b000};
                     o_mem_wdata     <= '0;
                     o_mem_be        <= BE_ALL;
                  end
               end
            end
            // ---- read request issue ----
            RD_REQ: begin
               if (i_mem_req_ready) begin
                  state           <= RD_WAIT;
                  o_mem_req_valid <= 1'b0;
               end
            end
            // ---- read data: combine and stage the write ----
            RD_WAIT: begin
               if (i_mem_rsp_valid) begin
                  state           <= WR_REQ;
                  o_mem_req_valid <= 1'b1;
                  o_mem_we        <= 1'b1;
`ifdef RISCV_AMO_WORD_EN
                  if (word_q) begin
                     old_q       <= {{HALF{rd_half[HALF-1]}}, rd_half};
                     o_mem_wdata <= hi_q ? {wr_half, {HALF{1'b0}}}
                                         : {{HALF{1'b0}}, wr_half};
                     o_mem_be    <= hi_q ? BE_HI : BE_LO;
                  end else
`endif
                  begin
                     old_q       <= i_mem_rdata;
                     o_mem_wdata <= amo_combine_d(op_q, i_mem_rdata, data_q);
                     o_mem_be    <= BE_ALL;
                  end
               end
            end
            // ---- write request issue ----
            WR_REQ: begin
               if (i_mem_req_ready) begin
                  state           <= WR_WAIT;
                  o_mem_req_valid <= 1'b0;
               end
            end
            // ---- write acknowledge ----
            WR_WAIT: begin
               if (i_mem_rsp_valid) begin
                  state       <= RSP;
                  o_rsp_valid <= 1'b1;
                  o_rsp_data  <= old_q;
                  o_rsp_err   <= 1'b0;
               end
            end
            // ---- response to core, held until taken ----
            RSP: begin
               if (i_rsp_ready) begin
                  state       <= IDLE;
                  o_rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_core_amo_unit.sv
// Testbench for riscv_core_amo_unit: directed and randomized AMO sequences
// against a word-addressed memory model and an arithmetic reference of the
// AMO semantics. Honours RISCV_AMO_WORD_EN the same way as the design.
module tb_riscv_core_amo_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_data;
  logic [3:0]  i_req_amo_op;
  logic        i_req_word;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [63:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_be;
  logic        i_mem_rsp_valid;
  logic [63:0] i_mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mem_m [logic [63:0]];

  riscv_core_amo_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_addr      (i_req_addr),
    .i_req_data      (i_req_data),
    .i_req_amo_op    (i_req_amo_op),
    .i_req_word      (i_req_word),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_data      (o_rsp_data),
    .o_rsp_err       (o_rsp_err),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_we        (o_mem_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_be        (o_mem_be),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rdata     (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AMO semantics at operand width w32 ? 32 : 64; result zero-extended.
  function automatic logic [63:0] ref_combine(input int op, input logic [63:0] a,
                                              input logic [63:0] b, input bit w32);
    longint          sa, sb;
    longint unsigned ua, ub, r;
    if (w32) begin
      sa = $signed(a[31:0]);
      sb = $signed(b[31:0]);
      ua = {32'b0, a[31:0]};
      ub = {32'b0, b[31:0]};
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
    end
    case (op)
      0: r = ub;
      1: r = ua + ub;
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = (sa > sb) ? ua : ub;
      6: r = (sa < sb) ? ua : ub;
      7: r = (ua > ub) ? ua : ub;
      default: r = (ua < ub) ? ua : ub;
    endcase
    if (w32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  // One complete AMO transaction. stall randomizes all handshakes and
  // injects stray memory responses; rst_at (>0) resets at that cycle;
  // chk_timing checks zero-wait cycle positions.
  task automatic run_op(input int op, input bit w, input logic [63:0] addr,
                        input logic [63:0] rs2, input bit stall, input int rst_at,
                        input bit chk_timing);
    logic [63:0] base, old, tmp, exp_wdata, exp_rsp, newmem;
    logic [7:0]  exp_be;
    logic [63:0] prev_addr, prev_wdata;
    logic [7:0]  prev_be;
    logic        prev_we;
    bit          exp_err, done, prev_hold, rsp_rd, rst_hit;
    int          half, rsp_due, nrd, nwr, nrsp, first_rd, first_wr, first_rsp;

    base = addr & ~64'h7;
    if (!mem_m.exists(base)) mem_m[base] = {$urandom, $urandom};
    old = mem_m[base];
    exp_err = (op > 8) || (w ? (addr[1:0] != 2'b00) : (addr[2:0] != 3'b000));
`ifndef RISCV_AMO_WORD_EN
    if (w) exp_err = 1'b1;
`endif
    half = addr[2] ? 1 : 0;
    if (w) begin
      tmp       = old >> (32 * half);
      exp_wdata = ref_combine(op, tmp, rs2, 1'b1) << (32 * half);
      exp_be    = (half == 1) ? 8'hF0 : 8'h0F;
      exp_rsp   = {{32{tmp[31]}}, tmp[31:0]};
    end else begin
      exp_wdata = ref_combine(op, old, rs2, 1'b0);
      exp_be    = 8'hFF;
      exp_rsp   = old;
    end
    if (exp_err) exp_rsp = 64'h0;
    newmem = old;
    for (int b = 0; b < 8; b++)
      if (exp_be[b]) newmem[8*b +: 8] = exp_wdata[8*b +: 8];

    // cycle 0: request accepted
    check("req_ready_idle", o_req_ready, 1'b1);
    i_req_valid  = 1'b1;
    i_req_addr   = addr;
    i_req_data   = rs2;
    i_req_amo_op = op[3:0];
    i_req_word   = w;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;

    done = 0; prev_hold = 0; rsp_rd = 0; rst_hit = 0;
    rsp_due = -1; nrd = 0; nwr = 0; nrsp = 0;
    first_rd = -1; first_wr = -1; first_rsp = -1;
    prev_addr = '0; prev_wdata = '0; prev_be = '0; prev_we = 1'b0;

    for (int j = 1; j <= 150; j++) begin
      if (j == rst_at) begin
        i_rst = 1'b1;
        i_mem_rsp_valid = 1'b0;
        i_mem_req_ready = 1'b0;
        i_rsp_ready = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("rst_mid_req_ready", o_req_ready, 1'b1);
        check("rst_mid_mem_valid", o_mem_req_valid, 1'b0);
        check("rst_mid_rsp_valid", o_rsp_valid, 1'b0);
        rst_hit = 1;
        break;
      end
      if (j == 1) check("busy_not_ready", o_req_ready, 1'b0);
      if (prev_hold) begin
        check("stall_valid", o_mem_req_valid, 1'b1);
        check("stall_we", o_mem_we, prev_we);
        check("stall_addr", o_mem_addr, prev_addr);
        check("stall_wdata", o_mem_wdata, prev_wdata);
        check("stall_be", o_mem_be, prev_be);
      end
      i_mem_rsp_valid = (j == rsp_due) ||
                        (stall && (j > rsp_due) && ($urandom_range(0, 3) == 0));
      i_mem_rdata = ((j == rsp_due) && rsp_rd) ? old : {$urandom, $urandom};
      prev_hold = 0;

      if (o_mem_req_valid) begin
        if (!o_mem_we && first_rd < 0) first_rd = j;
        if (o_mem_we && first_wr < 0) first_wr = j;
        i_mem_req_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (i_mem_req_ready) begin
          if (!o_mem_we) begin
            nrd++;
            rsp_rd = 1;
            check("rd_addr", o_mem_addr, base);
            check("rd_be", o_mem_be, 8'hFF);
          end else begin
            nwr++;
            rsp_rd = 0;
            check("wr_addr", o_mem_addr, base);
            check("wr_data", o_mem_wdata, exp_wdata);
            check("wr_be", o_mem_be, exp_be);
            mem_m[base] = newmem;
          end
          rsp_due = j + (stall ? $urandom_range(1, 3) : 1);
        end else begin
          prev_hold  = 1;
          prev_we    = o_mem_we;
          prev_addr  = o_mem_addr;
          prev_wdata = o_mem_wdata;
          prev_be    = o_mem_be;
        end
      end else begin
        i_mem_req_ready = ($urandom_range(0, 1) == 1);
      end

      if (o_rsp_valid) begin
        if (first_rsp < 0) first_rsp = j;
        check("rsp_data", o_rsp_data, exp_rsp);
        check("rsp_err", o_rsp_err, exp_err);
        i_rsp_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (i_rsp_ready) begin
          nrsp++;
          done = 1;
        end
      end else begin
        i_rsp_ready = ($urandom_range(0, 1) == 1);
      end

      @(posedge i_clk); #1;
      if (done) break;
    end
    i_mem_rsp_valid = 1'b0;

    if (!rst_hit) begin
      check("op_completed", done, 1'b1);
      check("read_count", nrd, exp_err ? 0 : 1);
      check("write_count", nwr, exp_err ? 0 : 1);
      check("rsp_count", nrsp, 1);
      if (chk_timing) begin
        check("rsp_cycle", first_rsp, exp_err ? 1 : 5);
        if (!exp_err) begin
          check("rd_cycle", first_rd, 1);
          check("wr_cycle", first_wr, 3);
        end
      end
    end
  endtask

  initial begin
    logic [63:0] rbase, raddr;
    int          rop;
    bit          rw;

    i_rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_data = '0;
    i_req_amo_op = '0; i_req_word = 1'b0; i_rsp_ready = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rdata = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_req_ready", o_req_ready, 1'b1);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_rsp_data", o_rsp_data, 64'h0);
    check("rst_rsp_err", o_rsp_err, 1'b0);
    check("rst_mem_valid", o_mem_req_valid, 1'b0);
    check("rst_mem_we", o_mem_we, 1'b0);
    check("rst_mem_addr", o_mem_addr, 64'h0);
    check("rst_mem_wdata", o_mem_wdata, 64'h0);
    check("rst_mem_be", o_mem_be, 8'h00);
    i_rst = 1'b0;

    // AMOADD.D, zero-wait
    mem_m[64'h100] = 64'h5;
    run_op(1, 1'b0, 64'h100, 64'h3, 1'b0, 0, 1'b1);
    // AMOMAX.D / AMOMAXU.D on all-ones vs 1
    mem_m[64'h200] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_op(5, 1'b0, 64'h200, 64'h1, 1'b0, 0, 1'b1);
    mem_m[64'h200] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_op(7, 1'b0, 64'h200, 64'h1, 1'b0, 0, 1'b1);
    // AMOMIN.W upper half
    mem_m[64'h100] = 64'h8000_0000_0000_0000;
    run_op(6, 1'b1, 64'h104, 64'h7FFF_FFFF, 1'b0, 0, 1'b1);
    // AMOADD.W lower half, 32-bit wrap
    mem_m[64'h400] = 64'h1234_5678_FFFF_FFFF;
    run_op(1, 1'b1, 64'h400, 64'h2, 1'b0, 0, 1'b1);
    // error paths: misaligned .D, illegal op, misaligned .W
    run_op(0, 1'b0, 64'h104, 64'h55, 1'b0, 0, 1'b1);
    run_op(10, 1'b0, 64'h100, 64'h55, 1'b0, 0, 1'b1);
    run_op(3, 1'b1, 64'h102, 64'h55, 1'b0, 0, 1'b1);

    // randomized operations with stalls
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: rbase = 64'h0;
        1: rbase = 64'h8;
        2: rbase = 64'h1000;
        default: rbase = 64'hFFFF_FFFF_FFFF_FFF8;
      endcase
      raddr = rbase;
      if ($urandom_range(0, 9) == 0) raddr = rbase | 64'($urandom_range(1, 7));
      else if ($urandom_range(0, 1) == 1) raddr = rbase | 64'h4;
      rw  = ($urandom_range(0, 1) == 1);
      rop = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      run_op(rop, rw, raddr, {$urandom, $urandom}, 1'b1, 0, 1'b0);
    end

    // reset while in WR_WAIT, stray response in IDLE, then AMOXOR.D
    mem_m[64'h300] = 64'hA5A5_0000_FFFF_1234;
    run_op(1, 1'b0, 64'h300, 64'h7, 1'b0, 4, 1'b0);
    i_mem_rsp_valid = 1'b1;
    i_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge i_clk); #1;
    i_mem_rsp_valid = 1'b0;
    check("stray_idle_ready", o_req_ready, 1'b1);
    check("stray_idle_rsp", o_rsp_valid, 1'b0);
    run_op(4, 1'b0, 64'h300, 64'h0F0F_F0F0_1111_2222, 1'b0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
